// File: rtl/nbody_host_sequencer.sv
// nbody_host_sequencer: runs one N-body accelerator job over a simple memory-mapped bus
// (configure, stream bodies in, start, poll DONE, acknowledge, fetch results, release).
// Optional: define NBODY_POLL_TIMEOUT_EN to bound DONE polling with a 32-bit timeout
// that raises a sticky error and skips the result fetch.
module nbody_host_sequencer #(
    parameter int BODIES       = 512,
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(BODIES)-1:0] cfg_n_bodies,
    input  logic [DATA_WIDTH-1:0]     cfg_gap,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [ADDR_WIDTH-1:0]     avm_address,
    output logic                      avm_write,
    output logic                      avm_read,
    output logic                      avm_chipselect,
    output logic [DATA_WIDTH-1:0]     avm_writedata,
    input  logic [DATA_WIDTH-1:0]     avm_readdata
);
    localparam int IW = $clog2(BODIES);
    localparam int OW = ADDR_WIDTH - IW;
    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam logic [OW-1:0] OP_GO   = OW'(8'h00);
    localparam logic [OW-1:0] OP_ACK  = OW'(8'h01);
    localparam logic [OW-1:0] OP_N    = OW'(8'h02);
    localparam logic [OW-1:0] OP_BODY = OW'(8'h03);
    localparam logic [OW-1:0] OP_GAP  = OW'(8'h08);
    localparam logic [OW-1:0] OP_DONE = OW'(8'h40);
    localparam logic [OW-1:0] OP_RES  = OW'(8'h41);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_N, S_CFG_GAP, S_LOAD, S_GO_SET, S_POLL,
        S_POLL_WAIT, S_ACK, S_FETCH, S_FETCH_WAIT, S_RELEASE, S_FIN
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         n_q, n_d;
    logic [DATA_WIDTH-1:0] gap_q, gap_d;
    logic [IW-1:0]         b_q, b_d;
    logic [2:0]            f_q, f_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic                  last_q, last_d;
    logic                  rel_q, rel_d;
    logic                  ov_q, ov_d;
    logic [DATA_WIDTH-1:0] od_q, od_d;
    logic                  last_body, lat_done, fetch_go, to_hit;
    logic [OW-1:0]         op;
    logic [IW-1:0]         idx;

    assign last_body = b_q == n_q - IW'(1);
    assign lat_done  = lat_q == LW'(READ_LATENCY);
    assign fetch_go  = !last_q && (!ov_q || out_ready);

`ifdef NBODY_POLL_TIMEOUT_EN
    logic [31:0] to_q, to_d;
    logic        err_q, err_d;
    logic        polling;

    assign polling = state_q == S_POLL || state_q == S_POLL_WAIT;
    assign to_hit  = polling && to_q == '1;
    assign error   = err_q;

    // poll timeout restarts with each job's GO; error stays set until reset
    always_comb begin
        to_d  = state_q == S_GO_SET ? '0 : polling ? to_q + 32'd1 : to_q;
        err_d = err_q | to_hit;
    end

    // timeout state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end
`else
    assign to_hit = 1'b0;
    assign error  = 1'b0;
`endif

    // state and datapath registers; reset aborts a job without touching the accelerator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            gap_q   <= '0;
            b_q     <= '0;
            f_q     <= '0;
            lat_q   <= '0;
            last_q  <= 1'b0;
            rel_q   <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            gap_q   <= gap_d;
            b_q     <= b_d;
            f_q     <= f_d;
            lat_q   <= lat_d;
            last_q  <= last_d;
            rel_q   <= rel_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end

    // next-state sequencing of the job phases
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (start) state_d = cfg_n_bodies == '0 ? S_FIN : S_CFG_N;
            S_CFG_N:      state_d = S_CFG_GAP;
            S_CFG_GAP:    state_d = S_LOAD;
            S_LOAD:       if (in_valid && f_q == 3'd4 && last_body) state_d = S_GO_SET;
            S_GO_SET:     state_d = S_POLL;
            S_POLL:       state_d = S_POLL_WAIT;
            S_POLL_WAIT:  if (lat_done) state_d = avm_readdata[0] ? S_ACK : S_POLL;
            S_ACK:        state_d = S_FETCH;
            S_FETCH:      state_d = last_q ? (ov_q ? S_FETCH : S_RELEASE) : fetch_go ? S_FETCH_WAIT : S_FETCH;
            S_FETCH_WAIT: if (lat_done) state_d = S_FETCH;
            S_RELEASE:    if (rel_q) state_d = S_FIN;
            S_FIN:        state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
        if (to_hit) state_d = S_RELEASE;
    end

    // counters, read-latency timer and the result holding register
    always_comb begin
        n_d    = n_q;
        gap_d  = gap_q;
        b_d    = b_q;
        f_d    = f_q;
        lat_d  = lat_q;
        last_d = last_q;
        rel_d  = rel_q;
        ov_d   = ov_q && !out_ready;
        od_d   = od_q;
        case (state_q)
            S_IDLE: if (start) begin
                n_d    = cfg_n_bodies;
                gap_d  = cfg_gap;
                b_d    = '0;
                f_d    = '0;
                last_d = 1'b0;
                rel_d  = 1'b0;
            end
            S_LOAD: if (in_valid) begin
                f_d = f_q == 3'd4 ? 3'd0 : f_q + 3'd1;
                b_d = f_q != 3'd4 ? b_q : last_body ? '0 : b_q + IW'(1);
            end
            S_POLL, S_FETCH: lat_d = LW'(1);
            S_POLL_WAIT: lat_d = lat_q + LW'(1);
            S_FETCH_WAIT: begin
                lat_d = lat_q + LW'(1);
                if (lat_done) begin
                    od_d = avm_readdata;
                    ov_d = 1'b1;
                    f_d  = {2'b00, !f_q[0]};
                    if (f_q[0]) begin
                        last_d = last_body;
                        b_d    = last_body ? b_q : b_q + IW'(1);
                    end
                end
            end
            S_RELEASE: rel_d = 1'b1;
            default: ;
        endcase
    end

    // bus strobes and stream handshakes decoded from the current state
    always_comb begin
        in_ready      = 1'b0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        done          = 1'b0;
        op            = '0;
        idx           = '0;
        avm_writedata = '0;
        case (state_q)
            S_CFG_N: begin
                avm_write     = 1'b1;
                op            = OP_N;
                avm_writedata = DATA_WIDTH'(n_q);
            end
            S_CFG_GAP: begin
                avm_write     = 1'b1;
                op            = OP_GAP;
                avm_writedata = gap_q;
            end
            S_LOAD: begin
                in_ready      = 1'b1;
                avm_write     = in_valid;
                op            = OP_BODY + OW'(f_q);
                idx           = b_q;
                avm_writedata = in_data;
            end
            S_GO_SET: begin
                avm_write     = 1'b1;
                op            = OP_GO;
                avm_writedata = DATA_WIDTH'(1);
            end
            S_POLL: begin
                avm_read = 1'b1;
                op       = OP_DONE;
            end
            S_ACK: begin
                avm_write     = 1'b1;
                op            = OP_ACK;
                avm_writedata = DATA_WIDTH'(1);
            end
            S_FETCH: begin
                avm_read = fetch_go;
                op       = OP_RES + OW'(f_q[0]);
                idx      = b_q;
            end
            S_RELEASE: begin
                avm_write = 1'b1;
                op        = rel_q ? OP_GO : OP_ACK;
            end
            S_FIN: done = 1'b1;
            default: ;
        endcase
    end

    assign busy           = state_q != S_IDLE;
    assign avm_chipselect = avm_write | avm_read;
    assign avm_address    = {op, idx};
    assign out_valid      = ov_q;
    assign out_data       = od_q;
endmodule

// File: tb/tb_nbody_host_sequencer.sv
// tb_nbody_host_sequencer: scoreboard bench; expected bus traffic and results are queued when a job is driven
module tb_nbody_host_sequencer;
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
    } bus_t;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [8:0]  cfg_n_bodies = '0;
    logic [63:0] cfg_gap = '0, in_data = '0, out_data, avm_writedata;
    logic [63:0] avm_readdata = '0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic        busy, done, error, avm_write, avm_read, avm_chipselect;
    logic [15:0] avm_address;
    logic [151:0] all_out;

    bus_t        exp_bus[$], obs_bus[$];
    logic [63:0] exp_out[$], obs_out[$];
    int n_cmp = 0, n_bad = 0, done_cnt = 0, proto_bad = 0, stall_rd = 0, stall_chg = 0;
    int poll_cnt = 0, poll_goal = 0, job_id = 0;
    bit stalling = 1'b0;

    nbody_host_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_n_bodies(cfg_n_bodies), .cfg_gap(cfg_gap),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .error(error),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_chipselect(avm_chipselect), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
    );

    assign all_out = {in_ready, out_valid, out_data, busy, done, error, avm_address,
                      avm_write, avm_read, avm_chipselect, avm_writedata};

    always #5 clk = ~clk;

    // accelerator model: one-cycle read latency, DONE reads 1 once poll_goal is reached
    always @(posedge clk) begin
        if (avm_read && avm_address[15:9] == 7'h40) begin
            avm_readdata <= {63'd0, poll_cnt >= poll_goal};
            poll_cnt     <= poll_cnt + 1;
        end else if (avm_read)
            avm_readdata <= {avm_address[15:9] == 7'h41 ? 8'hA1 : 8'hB2, 47'd0, avm_address[8:0]};
        else
            avm_readdata <= 64'hDEAD_BEEF_0BAD_F00E;
    end

    // bus and status monitor sampling mid-cycle
    always begin
        @(negedge clk);
        #2;
        if (avm_write || avm_read) obs_bus.push_back({avm_write, avm_address, avm_write ? avm_writedata : 64'd0});
        if (avm_chipselect !== (avm_write | avm_read) || (avm_write && avm_read)) proto_bad++;
        if (avm_write && in_ready && !in_valid) proto_bad++;
        if (stalling && avm_read) stall_rd++;
        if (done) done_cnt++;
    end

    function automatic logic [63:0] beat(input int k);
        return {16'hC0DE, 16'(job_id), 32'(k)};
    endfunction

    task automatic drive_job(input int n, input logic [63:0] gap, input bit toggle, input int polls,
                             input int stall, input int abort_beats, input bit restart);
        int beats, d0;
        job_id++;
        beats = abort_beats >= 0 ? abort_beats : 5 * n;
        d0 = done_cnt;
        exp_bus.push_back({1'b1, 16'h0400, 64'(n)});
        exp_bus.push_back({1'b1, 16'h1000, gap});
        for (int k = 0; k < beats; k++) exp_bus.push_back({1'b1, 16'(((3 + k % 5) << 9) | (k / 5)), beat(k)});
        if (abort_beats < 0) begin
            exp_bus.push_back({1'b1, 16'h0000, 64'd1});
            repeat (polls) exp_bus.push_back({1'b0, 16'h8000, 64'd0});
            exp_bus.push_back({1'b1, 16'h0200, 64'd1});
            for (int b = 0; b < n; b++) begin
                exp_bus.push_back({1'b0, 16'(32'h8200 | b), 64'd0});
                exp_bus.push_back({1'b0, 16'(32'h8400 | b), 64'd0});
                exp_out.push_back({8'hA1, 47'd0, 9'(b)});
                exp_out.push_back({8'hB2, 47'd0, 9'(b)});
            end
            exp_bus.push_back({1'b1, 16'h0200, 64'd0});
            exp_bus.push_back({1'b1, 16'h0000, 64'd0});
        end
        poll_goal = poll_cnt + polls - 1;
        @(negedge clk);
        start = 1'b1;
        cfg_n_bodies = 9'(n);
        cfg_gap = gap;
        @(negedge clk);
        start = 1'b0;
        fork
            begin
                int k = 0, c = 0;
                bit pulsed = 1'b0;
                while (k < beats && c < 20000) begin
                    @(negedge clk);
                    c++;
                    start = restart && k == 3 && !pulsed;
                    if (start) begin
                        pulsed = 1'b1;
                        cfg_n_bodies = 9'd7;
                    end
                    in_valid = toggle ? (c % 2 == 1) : 1'b1;
                    in_data = beat(k);
                    if (in_valid && in_ready) k++;
                end
                @(negedge clk);
                in_valid = 1'b0;
                start = 1'b0;
            end
            begin
                int got = 0, low = stall, c = 0;
                bit seen = 1'b0;
                logic [63:0] held = '0;
                out_ready = 1'b1;
                while (abort_beats < 0 && got < 2 * n && c < 30000) begin
                    @(negedge clk);
                    c++;
                    if (out_valid && !seen) begin
                        seen = 1'b1;
                        held = out_data;
                    end
                    stalling = seen && low > 0;
                    out_ready = !stalling;
                    if (stalling) begin
                        low--;
                        if (out_data !== held || !out_valid) stall_chg++;
                    end
                    if (out_valid && out_ready) begin
                        got++;
                        obs_out.push_back(out_data);
                    end
                end
                @(negedge clk);
                out_ready = 1'b0;
                stalling = 1'b0;
            end
            begin
                int c = 0;
                while (abort_beats < 0 && done_cnt == d0 && c < 30000) begin
                    @(negedge clk);
                    c++;
                end
            end
        join
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        n_cmp++;
        if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h required 0", all_out); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        n_cmp++;
        if (all_out !== '0) begin n_bad++; $display("FAIL idle_outputs: got %h required 0", all_out); end
    endtask

    task automatic test_basic();
        bus_t e, o;
        int d0 = done_cnt;
        obs_bus.delete(); obs_out.delete(); proto_bad = 0;
        drive_job(2, 64'd3, 1'b0, 3, 0, -1, 1'b0);
        n_cmp++;
        if (obs_bus.size() != exp_bus.size()) begin n_bad++; $display("FAIL basic_bus_count: got %0d required %0d", obs_bus.size(), exp_bus.size()); end
        while (exp_bus.size() > 0 && obs_bus.size() > 0) begin
            e = exp_bus.pop_front(); o = obs_bus.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL basic_bus_op: got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data); end
        end
        n_cmp++;
        if (obs_out.size() != exp_out.size()) begin n_bad++; $display("FAIL basic_out_count: got %0d required %0d", obs_out.size(), exp_out.size()); end
        while (exp_out.size() > 0 && obs_out.size() > 0) begin
            logic [63:0] x = exp_out.pop_front(), y = obs_out.pop_front(); n_cmp++;
            if (y !== x) begin n_bad++; $display("FAIL basic_out_data: got %h required %h", y, x); end
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_done: got pulses=%0d busy=%0b required 1/0", done_cnt - d0, busy); end
        n_cmp++;
        if (proto_bad != 0 || error !== 1'b0) begin n_bad++; $display("FAIL basic_protocol: got violations=%0d error=%0b required 0/0", proto_bad, error); end
        exp_bus.delete(); exp_out.delete();
    endtask

    task automatic test_in_throttle();
        bus_t e, o;
        int d0 = done_cnt;
        obs_bus.delete(); obs_out.delete(); proto_bad = 0;
        drive_job(3, 64'h1234_5678_9ABC_DEF0, 1'b1, 1, 0, -1, 1'b0);
        n_cmp++;
        if (obs_bus.size() != exp_bus.size()) begin n_bad++; $display("FAIL throttle_bus_count: got %0d required %0d", obs_bus.size(), exp_bus.size()); end
        while (exp_bus.size() > 0 && obs_bus.size() > 0) begin
            e = exp_bus.pop_front(); o = obs_bus.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL throttle_bus_op: got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data); end
        end
        while (exp_out.size() > 0 && obs_out.size() > 0) begin
            logic [63:0] x = exp_out.pop_front(), y = obs_out.pop_front(); n_cmp++;
            if (y !== x) begin n_bad++; $display("FAIL throttle_out_data: got %h required %h", y, x); end
        end
        n_cmp++;
        if (proto_bad != 0 || done_cnt - d0 != 1) begin n_bad++; $display("FAIL throttle_protocol: got violations=%0d pulses=%0d required 0/1", proto_bad, done_cnt - d0); end
        exp_bus.delete(); exp_out.delete();
    endtask

    task automatic test_backpressure();
        bus_t e, o;
        int d0 = done_cnt;
        obs_bus.delete(); obs_out.delete(); stall_rd = 0; stall_chg = 0;
        drive_job(2, 64'd5, 1'b0, 2, 20, -1, 1'b0);
        n_cmp++;
        if (stall_rd != 0 || stall_chg != 0) begin n_bad++; $display("FAIL stall_hold: got reads=%0d data_changes=%0d required 0/0", stall_rd, stall_chg); end
        n_cmp++;
        if (obs_bus.size() != exp_bus.size()) begin n_bad++; $display("FAIL stall_bus_count: got %0d required %0d", obs_bus.size(), exp_bus.size()); end
        while (exp_bus.size() > 0 && obs_bus.size() > 0) begin
            e = exp_bus.pop_front(); o = obs_bus.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL stall_bus_op: got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data); end
        end
        n_cmp++;
        if (obs_out.size() != exp_out.size()) begin n_bad++; $display("FAIL stall_out_count: got %0d required %0d", obs_out.size(), exp_out.size()); end
        while (exp_out.size() > 0 && obs_out.size() > 0) begin
            logic [63:0] x = exp_out.pop_front(), y = obs_out.pop_front(); n_cmp++;
            if (y !== x) begin n_bad++; $display("FAIL stall_out_data: got %h required %h", y, x); end
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL stall_done: got %0d pulses required 1", done_cnt - d0); end
        exp_bus.delete(); exp_out.delete();
    endtask

    task automatic test_zero_and_busy();
        bus_t e, o;
        int d0 = done_cnt;
        obs_bus.delete(); obs_out.delete();
        @(negedge clk);
        start = 1'b1; cfg_n_bodies = 9'd0; cfg_gap = 64'd99;
        @(negedge clk);
        start = 1'b0;
        #2;
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done_next_cycle: got done=%0b required 1", done); end
        @(negedge clk);
        #2;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_done_single: got done=%0b busy=%0b required 0/0", done, busy); end
        n_cmp++;
        if (obs_bus.size() != 0 || done_cnt - d0 != 1) begin n_bad++; $display("FAIL zero_no_traffic: got strobes=%0d pulses=%0d required 0/1", obs_bus.size(), done_cnt - d0); end
        obs_bus.delete();
        d0 = done_cnt;
        drive_job(4, 64'd9, 1'b0, 1, 0, -1, 1'b1);
        n_cmp++;
        if (obs_bus.size() != exp_bus.size()) begin n_bad++; $display("FAIL busy_start_bus_count: got %0d required %0d", obs_bus.size(), exp_bus.size()); end
        while (exp_bus.size() > 0 && obs_bus.size() > 0) begin
            e = exp_bus.pop_front(); o = obs_bus.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL busy_start_bus_op: got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data); end
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL busy_start_done: got pulses=%0d busy=%0b required 1/0", done_cnt - d0, busy); end
        exp_bus.delete(); exp_out.delete(); obs_out.delete();
    endtask

    task automatic test_reset_mid_job();
        bus_t e, o;
        int d0;
        obs_bus.delete(); obs_out.delete();
        drive_job(8, 64'd7, 1'b0, 1, 0, 25, 1'b0);
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_load: got busy=%0b in_ready=%0b required 1/1", busy, in_ready); end
        @(negedge clk);
        rst = 1'b1;
        #2;
        n_cmp++;
        if (all_out !== '0) begin n_bad++; $display("FAIL abort_outputs: got %h required 0", all_out); end
        @(negedge clk);
        #2;
        n_cmp++;
        if (all_out !== '0) begin n_bad++; $display("FAIL abort_outputs_held: got %h required 0", all_out); end
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (obs_bus.size() != exp_bus.size()) begin n_bad++; $display("FAIL abort_bus_count: got %0d required %0d", obs_bus.size(), exp_bus.size()); end
        while (exp_bus.size() > 0 && obs_bus.size() > 0) begin
            e = exp_bus.pop_front(); o = obs_bus.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL abort_bus_op: got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data); end
        end
        exp_bus.delete(); obs_bus.delete();
        d0 = done_cnt;
        drive_job(3, 64'd11, 1'b0, 2, 0, -1, 1'b0);
        n_cmp++;
        if (obs_bus.size() != exp_bus.size()) begin n_bad++; $display("FAIL rerun_bus_count: got %0d required %0d", obs_bus.size(), exp_bus.size()); end
        while (exp_bus.size() > 0 && obs_bus.size() > 0) begin
            e = exp_bus.pop_front(); o = obs_bus.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL rerun_bus_op: got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data); end
        end
        while (exp_out.size() > 0 && obs_out.size() > 0) begin
            logic [63:0] x = exp_out.pop_front(), y = obs_out.pop_front(); n_cmp++;
            if (y !== x) begin n_bad++; $display("FAIL rerun_out_data: got %h required %h", y, x); end
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL rerun_done: got %0d pulses required 1", done_cnt - d0); end
        exp_bus.delete(); exp_out.delete();
    endtask

    task automatic test_max_bodies();
        bus_t e, o;
        int d0 = done_cnt;
        obs_bus.delete(); obs_out.delete();
        drive_job(511, 64'd1, 1'b0, 1, 0, -1, 1'b0);
        n_cmp++;
        if (obs_bus.size() != exp_bus.size()) begin n_bad++; $display("FAIL max_bus_count: got %0d required %0d", obs_bus.size(), exp_bus.size()); end
        while (exp_bus.size() > 0 && obs_bus.size() > 0) begin
            e = exp_bus.pop_front(); o = obs_bus.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL max_bus_op: got wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h", o.wr, o.addr, o.data, e.wr, e.addr, e.data); end
        end
        n_cmp++;
        if (obs_out.size() != exp_out.size()) begin n_bad++; $display("FAIL max_out_count: got %0d required %0d", obs_out.size(), exp_out.size()); end
        while (exp_out.size() > 0 && obs_out.size() > 0) begin
            logic [63:0] x = exp_out.pop_front(), y = obs_out.pop_front(); n_cmp++;
            if (y !== x) begin n_bad++; $display("FAIL max_out_data: got %h required %h", y, x); end
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL max_done: got pulses=%0d busy=%0b required 1/0", done_cnt - d0, busy); end
        exp_bus.delete(); exp_out.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_in_throttle();
        test_backpressure();
        test_zero_and_busy();
        test_reset_mid_job();
        test_max_bodies();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nbody_host_sequencer.md
NBODY_HOST_SEQUENCER -- requirements
Module: nbody_host_sequencer

Interface
REQ-001 SHALL have parameter BODIES, default 512, the maximum body count.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the bus data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, the bus address width; the opcode is addr[15:9] and the body index is addr[8:0].
REQ-004 SHALL have parameter READ_LATENCY, default 1, the number of cycles from avm_read to valid avm_readdata.
REQ-005 SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-006 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to run one simulation job.
- cfg_n_bodies  in  9  body count; sampled on start.
- cfg_gap  in  64  step count; sampled on start.
- in_valid/in_ready  in/out  1  body-data stream handshake.
- in_data  in  64  per body, in order: x, y, m, vx, vy.
- out_valid/out_ready  in/out  1  result stream handshake (out_valid is the output, out_ready the input).
- out_data  out  64  per body, in order: x, then y.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when a job completes.
- error  out  1  sticky timeout flag.
- avm_address  out  16  accelerator address.
- avm_write  out  1  bus write strobe.
- avm_read  out  1  bus read strobe.
- avm_chipselect  out  1  bus chip select.
- avm_writedata  out  64  bus write data.
- avm_readdata  in  64  bus read data.

Function
REQ-007 SHALL issue at most one bus operation per cycle; avm_chipselect SHALL equal avm_write OR avm_read; each strobe SHALL last exactly one cycle.
REQ-008 States, in order: IDLE, CFG_N, CFG_GAP, LOAD, GO_SET, POLL, POLL_WAIT, ACK, FETCH, FETCH_WAIT, RELEASE, FIN.
- IDLE → CFG_N on start while idle.
- start is ignored while busy=1.
REQ-009 CFG_N SHALL write cfg_n_bodies, zero-extended, to opcode 0x02. CFG_GAP SHALL write cfg_gap to opcode 0x08.
REQ-010 LOAD SHALL loop over body b = 0..n-1 and field f = x, y, m, vx, vy.
- in_ready=1 only in LOAD.
- On each accepted beat, SHALL write in_data to opcode 0x03+f, index b, in the same cycle.
- No write occurs without in_valid.
REQ-011 GO_SET SHALL write 1 to opcode 0x00. POLL SHALL read opcode 0x40, then wait READ_LATENCY cycles in POLL_WAIT.
- If readdata[0]=1 → ACK.
- Otherwise → POLL.
REQ-012 ACK SHALL write 1 to opcode 0x01.
REQ-013 FETCH SHALL loop per body b: read opcode 0x41 index b, then opcode 0x42 index b.
- Each captured word is presented on out_data with out_valid held until out_ready.
- The next read is not issued while out_valid=1 and out_ready=0.
REQ-014 RELEASE SHALL write 0 to opcode 0x01, then 0 to opcode 0x00, on consecutive cycles.
REQ-015 FIN SHALL pulse done for one cycle, then return to IDLE.
REQ-016 start with cfg_n_bodies=0 SHALL pulse done on the next cycle with no bus traffic.
REQ-017 Body index SHALL be 9 bits; the final body is n-1. A count of 511 SHALL be legal and SHALL not wrap the counter.
REQ-018 avm_address SHALL be {opcode[6:0], index[8:0]}; index is 0 for non-body opcodes.
REQ-019 busy SHALL be 1 in every state except IDLE.

Reset
REQ-020 On rst, the block SHALL enter IDLE and drive the following outputs to 0: in_ready, out_valid, out_data, busy, done, error, avm_address, avm_write, avm_read, avm_chipselect, avm_writedata.
REQ-021 rst mid-job SHALL abort immediately with no further bus strobes; the accelerator is left as-is.

Configuration
REQ-022 When NBODY_POLL_TIMEOUT_EN is defined:
- A 32-bit counter SHALL count POLL/POLL_WAIT cycles.
- On reaching 2^32-1, the block SHALL set error, go to RELEASE and skip FETCH.
- Without the macro, error SHALL be tied to 0 and polling SHALL be unbounded.

Verification
REQ-023 n=2, gap=3, 10 in beats, DONE read 1 on the third poll:
- Bus writes, in order: 0x0400=2, 0x1000=3, 0x0600/0x0800/0x0A00/0x0C00/0x0E00 for body 0, then the same +1 for body 1, then 0x0000=1.
- Then 3 DONE reads, 0x0200=1, reads 0x8200, 0x8400, 0x8201, 0x8401, writes 0x0200=0, 0x0000=0, one done pulse.
REQ-024 in_valid toggling every other cycle: avm_write occurs only on in_valid&in_ready cycles, and data order is preserved.
REQ-025 out_ready held low for 20 cycles after the first result: out_data stays stable, no read is issued, and the sequence resumes correctly afterwards.
REQ-026 start with n=0 → done at cycle+1 with zero avm strobes; start asserted while busy is ignored.
REQ-027 rst asserted during LOAD of body 5 → all outputs 0 next cycle; a new start runs a full job correctly.
REQ-028 With NBODY_POLL_TIMEOUT_EN, DONE held at 0 → error=1, RELEASE writes issued, no 0x41/0x42 reads, done pulses.
